// File: rtl/vmicro16_pkg.sv
// Shared vmicro16 definitions: APB bridge FSM encoding and default timeout.
package vmicro16_pkg;

  // Bridge FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StDone   = 2'd3
  } apb_state_e;

  // Default number of ACCESS wait cycles before a transfer is abandoned.
  localparam int unsigned ApbTimeoutDefault = 255;

endpackage

// File: rtl/apb_master_bridge.sv
// CPU-side request/ack port to APB master bridge. One transfer at a time:
// IDLE -> SETUP -> ACCESS (waits on PREADY, bounded by TIMEOUT) -> DONE.
// Every output is a register or a decode of the state register.
module apb_master_bridge
  import vmicro16_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 16,
  parameter int unsigned TIMEOUT   = ApbTimeoutDefault
) (
  input  logic                 clk,
  input  logic                 reset,
  // CPU side
  input  logic [BUS_WIDTH-1:0] S_MEM_ADDR,
  input  logic [BUS_WIDTH-1:0] S_MEM_IN,
  input  logic                 S_MEM_WE,
  input  logic                 S_REQ,
  output logic [BUS_WIDTH-1:0] S_MEM_OUT,
  output logic                 S_ACK,
  output logic                 S_ERR,
  output logic                 S_MEM_BUSY,
  // APB master side
  output logic [BUS_WIDTH-1:0] M_PADDR,
  output logic                 M_PWRITE,
  output logic                 M_PSELx,
  output logic                 M_PENABLE,
  output logic [BUS_WIDTH-1:0] M_PWDATA,
  input  logic [BUS_WIDTH-1:0] M_PRDATA,
  input  logic                 M_PREADY
);

  // Wait-cycle limit in the counter's own width.
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  apb_state_e           state_q, state_d;
  logic [BUS_WIDTH-1:0] paddr_q, paddr_d;
  logic [BUS_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                 pwrite_q, pwrite_d;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [7:0]           wait_q, wait_d;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Transfer datapath registers: latched request, read data, error flag, wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wait_q   <= '0;
    end else begin
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      wait_q   <= wait_d;
    end
  end

  // Next-state and datapath update; PREADY only matters in ACCESS.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    wait_d   = wait_q;
    unique case (state_q)
      StIdle: begin
        if (S_REQ) begin
          paddr_d  = S_MEM_ADDR;
          pwdata_d = S_MEM_IN;
          pwrite_d = S_MEM_WE;
          err_d    = 1'b0;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        wait_d  = '0;
        state_d = StAccess;
      end
      StAccess: begin
        if (M_PREADY) begin
          if (!pwrite_q) begin
            rdata_d = M_PRDATA;
          end
          state_d = StDone;
        end else if (wait_q == TimeoutCnt) begin
          // Slave never answered: report an error and return zero data.
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StDone;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    M_PSELx    = (state_q == StSetup) || (state_q == StAccess);
    M_PENABLE  = (state_q == StAccess);
    S_ACK      = (state_q == StDone);
    S_ERR      = (state_q == StDone) && err_q;
    S_MEM_BUSY = (state_q != StIdle);
    M_PADDR    = paddr_q;
    M_PWDATA   = pwdata_q;
    M_PWRITE   = pwrite_q;
    S_MEM_OUT  = rdata_q;
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a scoreboard of expected completions.
module tb_apb_master_bridge;

  localparam int unsigned BW = 16;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] s_mem_addr, s_mem_in, s_mem_out, m_paddr, m_pwdata, m_prdata;
  logic          s_mem_we, s_req, s_ack, s_err, s_mem_busy;
  logic          m_pwrite, m_psel, m_penable, m_pready;

  typedef struct {
    string         tag;
    logic [BW-1:0] out;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            vec_cnt = 0;
  int            err_cnt = 0;
  logic [BW-1:0] model_out = '0;

  apb_master_bridge #(
    .BUS_WIDTH(BW),
    .TIMEOUT  (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .S_MEM_ADDR(s_mem_addr),
    .S_MEM_IN  (s_mem_in),
    .S_MEM_WE  (s_mem_we),
    .S_REQ     (s_req),
    .S_MEM_OUT (s_mem_out),
    .S_ACK     (s_ack),
    .S_ERR     (s_err),
    .S_MEM_BUSY(s_mem_busy),
    .M_PADDR   (m_paddr),
    .M_PWRITE  (m_pwrite),
    .M_PSELx   (m_psel),
    .M_PENABLE (m_penable),
    .M_PWDATA  (m_pwdata),
    .M_PRDATA  (m_prdata),
    .M_PREADY  (m_pready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transfer. waits = ACCESS cycles with PREADY low before PREADY high.
  task automatic xfer(input string tag, input logic we, input logic [BW-1:0] addr,
                      input logic [BW-1:0] wdata, input logic [BW-1:0] rdata,
                      input int waits, input bit timeout, input bit keep_req,
                      input bit pre_ready);
    exp_t e;
    int   cyc;
    int   acc;
    bit   ack;
    e.tag = tag;
    e.err = timeout;
    e.out = timeout ? '0 : (we ? model_out : rdata);
    e.cyc = timeout ? 3 + int'(TO) : 3 + waits;
    sb.push_back(e);
    model_out = e.out;

    s_req = 1'b1; s_mem_we = we; s_mem_addr = addr; s_mem_in = wdata;
    m_prdata = rdata; m_pready = pre_ready;
    step();
    cyc = 1;
    if (!keep_req) s_req = 1'b0;
    // Request inputs are don't-care once latched.
    s_mem_addr = BW'($urandom); s_mem_in = BW'($urandom); s_mem_we = ~we;
    chk({tag, ":setup_ctl"}, {m_psel, m_penable, s_mem_busy, s_ack}, 4'b1010);
    chk({tag, ":setup_bus"}, {m_paddr, m_pwdata, m_pwrite}, {addr, wdata, we});

    acc = 0;
    ack = 0;
    for (int i = 0; i < 300 && !ack; i++) begin
      step();
      cyc++;
      if (s_ack) begin
        ack = 1;
      end else begin
        acc++;
        chk({tag, ":access_ctl"}, {m_psel, m_penable}, 2'b11);
        chk({tag, ":access_bus"}, {m_paddr, m_pwdata, m_pwrite}, {addr, wdata, we});
        m_pready = !timeout && (acc == waits + 1);
      end
    end
    m_pready = 1'b0;
    chk({tag, ":ack_seen"}, 64'(ack), 64'd1);
    if (ack) begin
      e = sb.pop_front();
      chk({e.tag, ":latency"}, 64'(cyc), 64'(e.cyc));
      chk({e.tag, ":done"}, {s_err, m_psel, m_penable, s_mem_busy}, {e.err, 3'b001});
      chk({e.tag, ":rdata"}, 64'(s_mem_out), 64'(e.out));
    end
    step();
    chk({tag, ":idle"}, {m_psel, m_penable, s_mem_busy, s_ack, s_err}, 5'b0);
  endtask

  initial begin
    reset = 1'b1; s_req = 1'b0; s_mem_we = 1'b0; s_mem_addr = '0; s_mem_in = '0;
    m_prdata = '0; m_pready = 1'b0;
    step();
    chk("reset_ctl", {m_psel, m_penable, m_pwrite, s_ack, s_err, s_mem_busy}, 6'b0);
    chk("reset_bus", {m_paddr, m_pwdata, s_mem_out}, 48'h0);
    reset = 1'b0;
    step();
    chk("post_reset_idle", {s_mem_busy, s_ack}, 2'b00);

    xfer("rd0", 1'b0, 16'h0081, 16'h0000, 16'h1234, 0, 0, 0, 0);
    xfer("wr3", 1'b1, 16'h0090, 16'hBEEF, 16'hDEAD, 3, 0, 0, 0);
    xfer("rd_wait_eq_to", 1'b0, 16'h00A0, 16'h0000, 16'h5A5A, int'(TO), 0, 0, 0);
    xfer("rd_timeout", 1'b0, 16'h00B0, 16'h0000, 16'h7777, 0, 1, 0, 0);
    xfer("rd_after_to", 1'b0, 16'h00C0, 16'h0000, 16'hC3C3, 1, 0, 0, 0);
    xfer("wr_after_rd", 1'b1, 16'h00C4, 16'h1111, 16'h2222, 0, 0, 0, 0);

    // S_REQ held high: each transfer starts right after the idle cycle.
    xfer("b2b_0", 1'b0, 16'h0100, 16'h0000, 16'hA001, 0, 0, 1, 0);
    xfer("b2b_1", 1'b1, 16'h0102, 16'h4242, 16'h0000, 0, 0, 1, 0);
    xfer("b2b_2", 1'b0, 16'h0104, 16'h0000, 16'hA003, 2, 0, 0, 0);

    // PREADY high outside ACCESS must not produce an ack or skip SETUP.
    m_pready = 1'b1;
    step();
    chk("pready_idle_0", {s_ack, s_mem_busy, m_psel}, 3'b000);
    step();
    chk("pready_idle_1", {s_ack, s_mem_busy, m_psel}, 3'b000);
    xfer("rd_pre_ready", 1'b0, 16'h0200, 16'h0000, 16'h0F0F, 0, 0, 0, 1);

    // Reset during ACCESS aborts the write.
    s_req = 1'b1; s_mem_we = 1'b1; s_mem_addr = 16'h0300; s_mem_in = 16'hCAFE;
    step();
    s_req = 1'b0;
    step();
    chk("abort_in_access", {m_psel, m_penable, m_pwrite}, 3'b111);
    #2 reset = 1'b1;
    #1;
    chk("abort_ctl", {m_psel, m_penable, m_pwrite, s_ack, s_err, s_mem_busy}, 6'b0);
    chk("abort_bus", {m_paddr, m_pwdata, s_mem_out}, 48'h0);
    model_out = '0;
    step();
    reset = 1'b0;
    step();
    chk("abort_no_ack", {s_ack, s_mem_busy}, 2'b00);
    step();
    chk("abort_no_ack2", {s_ack, s_mem_busy}, 2'b00);
    xfer("rd_after_reset", 1'b0, 16'h0081, 16'h0000, 16'h9876, 0, 0, 0, 0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
